bbox_frame_sched: RTL and testbench
===================================

// Module: bbox_frame_sched
// PURPOSE
//  Frame-level scheduler for the boundingbox engine. Waits for the capture side to
//  flag a complete frame, starts boundingbox on it, watches for done or a stall
//  timeout, and captures the box into a one-deep valid/ready result register. It
//  also toggles a ping-pong buffer select so capture and boundingbox never share a frame.
// PARAMETERS
//  COORD_W   11         coordinate width; matches boundingbox xMin/xMax/yMin/yMax
//  TO_CYCLES 2_000_000  max cycles from bb_start rise to bb_done before abort (>=2)
//  FCNT_W    16         width of the completed-frame counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        async active-low reset
//  enable       in   1        0 = accept no new frames; an in-flight frame still completes
//  frame_rdy    in   1        capture has a full frame in buffer buf_sel
//  frame_ack    out  1        1-cycle pulse: frame consumed (done or aborted)
//  buf_sel      out  1        buffer boundingbox reads; capture writes ~buf_sel
//  bb_start     out  1        to boundingbox start
//  bb_done      in   1        from boundingbox done
//  bb_xmin..bb_ymax in COORD_W each, boundingbox xMin,xMax,yMin,yMax
//  res_valid    out  1        result register holds an unread result
//  res_ready    in   1        consumer accepts result when res_valid&res_ready
//  res_xmin..res_ymax out COORD_W each, captured box
//  res_w,res_h  out  COORD_W+1  xmax-xmin+1, ymax-ymin+1; 0 when res_empty
//  res_empty    out  1        captured box invalid (xmin>xmax or ymin>ymax)
//  frame_cnt    out  FCNT_W   frames completed successfully, wraps to 0
//  err_timeout  out  1        sticky; set on abort, cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; every output 0 (buf_sel=0, bb_start=0, res_*=0, counters=0).
//  FSM IDLE -> RUN -> CAPT -> (OUT) -> IDLE, plus RUN -> ABORT -> IDLE.
//  IDLE: enable&frame_rdy -> RUN next cycle; timeout counter cleared.
//  RUN: bb_start=1, held level-high until bb_done sampled 1; counter +1 per cycle.
//   bb_done=1 -> CAPT; load bb_* into staging regs that same edge.
//   counter==TO_CYCLES-1 with bb_done=0 -> ABORT. bb_done wins if both occur on one cycle.
//  ABORT: bb_start=0; frame_ack pulses; err_timeout<=1; buf_sel unchanged; no result
//   produced; frame_cnt unchanged; -> IDLE.
//  CAPT: bb_start=0. Compute res_empty/w/h from staging regs, COORD_W+1-bit unsigned
//   subtraction; w,h forced to 0 when empty.
//   If the result slot is free (res_valid=0, or res_valid&res_ready this cycle): load
//   slot, res_valid<=1, frame_ack pulse, buf_sel toggles, frame_cnt+1 -> IDLE.
//   Otherwise -> OUT. No result is ever dropped or overwritten.
//  OUT: hold until the slot frees, then perform the CAPT load/ack/toggle -> IDLE.
//  Result slot: res_valid falls on res_valid&res_ready unless reloaded on the same edge.
//   res_* are stable while res_valid=1.
//  IDLE re-entry is gated on bb_done=0, so a done level held high by boundingbox is not
//   mistaken for a new completion.
//  frame_rdy is level; the producer drops it after frame_ack. frame_rdy=1 while
//   enable=0 is ignored.
//  Latency: frame_rdy -> bb_start = 1 cycle. bb_done -> res_valid = 2 cycles when the
//   slot is free.
//  Async reset mid-frame: FSM returns to IDLE at once and bb_start drops at once.
//   The pending result is lost.
// TESTING
//  T1 reset, frame_rdy=1, bb_done after 100 cycles with box (10,50,20,60), res_ready=1
//     -> bb_start 1 cycle after frame_rdy; res=(10,50,20,60), w=41,h=41; frame_ack 1 pulse;
//     buf_sel 0->1; frame_cnt=1
//  T2 box xmin=200,xmax=100 -> res_empty=1, res_w=res_h=0; frame_cnt still increments
//  T3 TO_CYCLES=64, bb_done never asserts -> bb_start falls after 64 cycles; err_timeout=1;
//     frame_ack pulse; res_valid stays 0; buf_sel unchanged
//  T4 res_ready=0, two back-to-back frames -> second waits in OUT; frame_ack for frame 2
//     only after the first handshake; both results read in order
//  T5 enable=0 with frame_rdy=1 -> bb_start stays 0 indefinitely; enable=1 -> starts
//  T6 rst_n low mid-RUN -> bb_start=0 and res_valid=0 immediately; frame_cnt=0

Source files
------------

// File: rtl/bbox_frame_sched.sv
// Frame scheduler for the boundingbox engine: starts a run per captured frame, watches
// for done or a stall timeout, and hands the box out through a one-deep result slot.
module bbox_frame_sched #(
   parameter int unsigned COORD_W   = 11,
   parameter int unsigned TO_CYCLES = 2_000_000,
   parameter int unsigned FCNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               frame_rdy,
   output logic               frame_ack,
   output logic               buf_sel,
   output logic               bb_start,
   input  logic               bb_done,
   input  logic [COORD_W-1:0] bb_xmin,
   input  logic [COORD_W-1:0] bb_xmax,
   input  logic [COORD_W-1:0] bb_ymin,
   input  logic [COORD_W-1:0] bb_ymax,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [COORD_W-1:0] res_xmin,
   output logic [COORD_W-1:0] res_xmax,
   output logic [COORD_W-1:0] res_ymin,
   output logic [COORD_W-1:0] res_ymax,
   output logic [COORD_W:0]   res_w,
   output logic [COORD_W:0]   res_h,
   output logic               res_empty,
   output logic [FCNT_W-1:0]  frame_cnt,
   output logic               err_timeout
);

   localparam int unsigned     DIM_W   = COORD_W + 1;
   localparam int unsigned     TO_W    = $clog2(TO_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_CAPT,
      S_OUT,
      S_ABORT
   } state_e;

   state_e              state_q, state_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [COORD_W-1:0]  stg_xmin_q, stg_xmin_d, stg_xmax_q, stg_xmax_d;
   logic [COORD_W-1:0]  stg_ymin_q, stg_ymin_d, stg_ymax_q, stg_ymax_d;
   logic [COORD_W-1:0]  res_xmin_q, res_xmin_d, res_xmax_q, res_xmax_d;
   logic [COORD_W-1:0]  res_ymin_q, res_ymin_d, res_ymax_q, res_ymax_d;
   logic [DIM_W-1:0]    res_w_q, res_w_d, res_h_q, res_h_d;
   logic                res_empty_q, res_empty_d;
   logic                res_valid_q, res_valid_d;
   logic                frame_ack_q, frame_ack_d;
   logic                buf_sel_q, buf_sel_d;
   logic                bb_start_q, bb_start_d;
   logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic                err_q, err_d;

   logic                slot_free_c, empty_c, load_c;
   logic [DIM_W-1:0]    w_c, h_c;

   // Next-state, staging and result-slot logic
   always_comb begin
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      stg_xmin_d  = stg_xmin_q;
      stg_xmax_d  = stg_xmax_q;
      stg_ymin_d  = stg_ymin_q;
      stg_ymax_d  = stg_ymax_q;
      res_xmin_d  = res_xmin_q;
      res_xmax_d  = res_xmax_q;
      res_ymin_d  = res_ymin_q;
      res_ymax_d  = res_ymax_q;
      res_w_d     = res_w_q;
      res_h_d     = res_h_q;
      res_empty_d = res_empty_q;
      res_valid_d = res_valid_q;
      frame_ack_d = 1'b0;
      buf_sel_d   = buf_sel_q;
      bb_start_d  = bb_start_q;
      frame_cnt_d = frame_cnt_q;
      err_d       = err_q;
      load_c      = 1'b0;

      slot_free_c = !res_valid_q || res_ready;
      empty_c     = (stg_xmin_q > stg_xmax_q) || (stg_ymin_q > stg_ymax_q);
      w_c = empty_c ? '0 : DIM_W'(stg_xmax_q) - DIM_W'(stg_xmin_q) + DIM_W'(1);
      h_c = empty_c ? '0 : DIM_W'(stg_ymax_q) - DIM_W'(stg_ymin_q) + DIM_W'(1);

      if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            to_cnt_d = '0;
            // Hold off while the previous ack is still out or done is still high
            if (enable && frame_rdy && !bb_done && !frame_ack_q) begin
               state_d    = S_RUN;
               bb_start_d = 1'b1;
            end
         end
         S_RUN: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (bb_done) begin
               state_d    = S_CAPT;
               bb_start_d = 1'b0;
               stg_xmin_d = bb_xmin;
               stg_xmax_d = bb_xmax;
               stg_ymin_d = bb_ymin;
               stg_ymax_d = bb_ymax;
            end else if (to_cnt_q == TO_LAST) begin
               state_d    = S_ABORT;
               bb_start_d = 1'b0;
            end
         end
         S_ABORT: begin
            frame_ack_d = 1'b1;
            err_d       = 1'b1;
            state_d     = S_IDLE;
         end
         S_CAPT, S_OUT: begin
            if (slot_free_c) begin
               load_c  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            state_d    = S_IDLE;
            bb_start_d = 1'b0;
         end
      endcase

      if (load_c) begin
         res_xmin_d  = stg_xmin_q;
         res_xmax_d  = stg_xmax_q;
         res_ymin_d  = stg_ymin_q;
         res_ymax_d  = stg_ymax_q;
         res_w_d     = w_c;
         res_h_d     = h_c;
         res_empty_d = empty_c;
         res_valid_d = 1'b1;
         frame_ack_d = 1'b1;
         buf_sel_d   = !buf_sel_q;
         frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         to_cnt_q    <= '0;
         stg_xmin_q  <= '0;
         stg_xmax_q  <= '0;
         stg_ymin_q  <= '0;
         stg_ymax_q  <= '0;
         res_xmin_q  <= '0;
         res_xmax_q  <= '0;
         res_ymin_q  <= '0;
         res_ymax_q  <= '0;
         res_w_q     <= '0;
         res_h_q     <= '0;
         res_empty_q <= 1'b0;
         res_valid_q <= 1'b0;
         frame_ack_q <= 1'b0;
         buf_sel_q   <= 1'b0;
         bb_start_q  <= 1'b0;
         frame_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         stg_xmin_q  <= stg_xmin_d;
         stg_xmax_q  <= stg_xmax_d;
         stg_ymin_q  <= stg_ymin_d;
         stg_ymax_q  <= stg_ymax_d;
         res_xmin_q  <= res_xmin_d;
         res_xmax_q  <= res_xmax_d;
         res_ymin_q  <= res_ymin_d;
         res_ymax_q  <= res_ymax_d;
         res_w_q     <= res_w_d;
         res_h_q     <= res_h_d;
         res_empty_q <= res_empty_d;
         res_valid_q <= res_valid_d;
         frame_ack_q <= frame_ack_d;
         buf_sel_q   <= buf_sel_d;
         bb_start_q  <= bb_start_d;
         frame_cnt_q <= frame_cnt_d;
         err_q       <= err_d;
      end
   end

   assign frame_ack   = frame_ack_q;
   assign buf_sel     = buf_sel_q;
   assign bb_start    = bb_start_q;
   assign res_valid   = res_valid_q;
   assign res_xmin    = res_xmin_q;
   assign res_xmax    = res_xmax_q;
   assign res_ymin    = res_ymin_q;
   assign res_ymax    = res_ymax_q;
   assign res_w       = res_w_q;
   assign res_h       = res_h_q;
   assign res_empty   = res_empty_q;
   assign frame_cnt   = frame_cnt_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_bbox_frame_sched.sv
// Bench for bbox_frame_sched: acts as capture producer, boundingbox engine and result
// consumer; expected boxes come from a plain-integer model of the result rules.
module tb_bbox_frame_sched;

   localparam int unsigned COORD_W   = 11;
   localparam int unsigned TO_CYCLES = 64;
   localparam int unsigned FCNT_W    = 4;

   typedef struct packed {
      logic [10:0] xmin;
      logic [10:0] xmax;
      logic [10:0] ymin;
      logic [10:0] ymax;
      logic [11:0] w;
      logic [11:0] h;
      logic        empty;
   } res_t;

   logic        clk, rst_n, enable, frame_rdy, frame_ack, buf_sel, bb_start, bb_done;
   logic [10:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
   logic        res_valid, res_ready, res_empty, err_timeout;
   logic [10:0] res_xmin, res_xmax, res_ymin, res_ymax;
   logic [11:0] res_w, res_h;
   logic [3:0]  frame_cnt;

   int   checks, errors;
   int   ack_cnt, ack_long;
   bit   ack_prev, rand_ready;
   res_t got_q[$];
   res_t exp_q[$];
   int   exp_cnt;
   bit   exp_buf, exp_err;

   bbox_frame_sched #(.COORD_W(COORD_W), .TO_CYCLES(TO_CYCLES), .FCNT_W(FCNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_rdy(frame_rdy),
      .frame_ack(frame_ack), .buf_sel(buf_sel), .bb_start(bb_start), .bb_done(bb_done),
      .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_xmin(res_xmin), .res_xmax(res_xmax), .res_ymin(res_ymin), .res_ymax(res_ymax),
      .res_w(res_w), .res_h(res_h), .res_empty(res_empty),
      .frame_cnt(frame_cnt), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record accepted results and ack pulses mid-cycle
   always @(negedge clk) begin
      res_t r;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         r = {res_xmin, res_xmax, res_ymin, res_ymax, res_w, res_h, res_empty};
         got_q.push_back(r);
      end
      if (frame_ack === 1'b1) begin
         ack_cnt++;
         if (ack_prev) ack_long++;
      end
      ack_prev = (frame_ack === 1'b1);
   end

   function automatic res_t model(input int x0, input int x1, input int y0, input int y1);
      res_t r;
      r.xmin  = 11'(x0);
      r.xmax  = 11'(x1);
      r.ymin  = 11'(y0);
      r.ymax  = 11'(y1);
      r.empty = (x0 > x1) || (y0 > y1);
      r.w     = r.empty ? 12'd0 : 12'(x1 - x0 + 1);
      r.h     = r.empty ? 12'd0 : 12'(y1 - y0 + 1);
      return r;
   endfunction

   task automatic note_frame(input int x0, input int x1, input int y0, input int y1);
      exp_q.push_back(model(x0, x1, y0, y1));
      exp_cnt++;
      exp_buf = !exp_buf;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) res_ready = ($urandom_range(0, 1) == 1);
   endtask

   task automatic start_frame(output int lat);
      frame_rdy = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (bb_start !== 1'b1 && lat < 50);
   endtask

   task automatic finish_bb(input int run, input int x0, input int x1, input int y0, input int y1);
      repeat (run - 1) tick();
      bb_xmin = 11'(x0);
      bb_xmax = 11'(x1);
      bb_ymin = 11'(y0);
      bb_ymax = 11'(y1);
      bb_done = 1'b1;
      tick();
      bb_done = 1'b0;
      bb_xmin = 11'($urandom);
      bb_xmax = 11'($urandom);
      bb_ymin = 11'($urandom);
      bb_ymax = 11'($urandom);
   endtask

   task automatic wait_ack(input int bound, output bit seen, output int got_sz);
      int n = 0;
      while (frame_ack !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      seen   = (frame_ack === 1'b1);
      got_sz = got_q.size();
      frame_rdy = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; frame_rdy = 1'b0; bb_done = 1'b0; res_ready = 1'b0;
      bb_xmin = '0; bb_xmax = '0; bb_ymin = '0; bb_ymax = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({frame_ack, buf_sel, bb_start, res_valid, res_xmin, res_xmax, res_ymin, res_ymax,
           res_w, res_h, res_empty, frame_cnt, err_timeout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs bb_start=%b res_valid=%b buf_sel=%b cnt=%0d exp all 0",
                  bb_start, res_valid, buf_sel, frame_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();
      checks++;
      if ({bb_start, res_valid, frame_ack, frame_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_release bb_start=%b res_valid=%b exp 0", bb_start, res_valid);
      end
   endtask

   task automatic test_basic();
      int lat, d, gs, a0;
      bit seen;
      res_t e;
      got_q.delete(); exp_q.delete();
      enable = 1'b1; res_ready = 1'b1; a0 = ack_cnt;
      start_frame(lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL t1_start_latency got=%0d exp=1", lat); end
      finish_bb(40, 10, 50, 20, 60);
      d = 1;
      while (res_valid !== 1'b1 && d < 10) begin tick(); d++; end
      checks++;
      if (d !== 2) begin errors++; $display("FAIL t1_done_to_valid got=%0d exp=2", d); end
      wait_ack(5, seen, gs);
      checks++;
      if (!seen) begin errors++; $display("FAIL t1_ack got=0 exp=1"); end
      repeat (2) tick();
      note_frame(10, 50, 20, 60);
      e.xmin = 11'd10; e.xmax = 11'd50; e.ymin = 11'd20; e.ymax = 11'd60;
      e.w = 12'd41; e.h = 12'd41; e.empty = 1'b0;
      checks++;
      if (got_q.size() != 1) begin
         errors++; $display("FAIL t1_result_count got=%0d exp=1", got_q.size());
      end else if (got_q[0] !== e) begin
         errors++; $display("FAIL t1_result got=%h exp=%h", got_q[0], e);
      end
      checks++;
      if (ack_cnt - a0 != 1) begin errors++; $display("FAIL t1_ack_count got=%0d exp=1", ack_cnt - a0); end
      checks++;
      if (buf_sel !== 1'b1) begin errors++; $display("FAIL t1_buf_sel got=%b exp=1", buf_sel); end
      checks++;
      if (frame_cnt !== 4'd1) begin errors++; $display("FAIL t1_frame_cnt got=%0d exp=1", frame_cnt); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_empty();
      int boxes[3][4] = '{'{200, 100, 30, 40}, '{5, 9, 300, 299}, '{7, 7, 7, 7}};
      int lat, gs;
      bit seen;
      foreach (boxes[i]) begin
         start_frame(lat);
         finish_bb(5, boxes[i][0], boxes[i][1], boxes[i][2], boxes[i][3]);
         wait_ack(10, seen, gs);
         note_frame(boxes[i][0], boxes[i][1], boxes[i][2], boxes[i][3]);
      end
      tick();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL t2_result_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL t2_result[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (frame_cnt !== 4'(exp_cnt)) begin
         errors++; $display("FAIL t2_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt % 16);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_timeout();
      int lat, hi, n, gs, a0;
      bit seen, b0;
      logic [3:0] c0;
      b0 = buf_sel; c0 = frame_cnt; a0 = ack_cnt;
      start_frame(lat);
      hi = 1; n = 0;
      while (bb_start === 1'b1 && n < 200) begin
         tick(); n++;
         if (bb_start === 1'b1) hi++;
      end
      checks++;
      if (hi != 64) begin errors++; $display("FAIL t3_start_high_cycles got=%0d exp=64", hi); end
      wait_ack(5, seen, gs);
      exp_err = 1'b1;
      checks++;
      if (!seen || ack_cnt - a0 != 1) begin
         errors++; $display("FAIL t3_ack got=%0d pulses exp=1", ack_cnt - a0);
      end
      checks++;
      if (err_timeout !== 1'b1) begin errors++; $display("FAIL t3_err got=%b exp=1", err_timeout); end
      checks++;
      if (res_valid !== 1'b0 || got_q.size() != 0) begin
         errors++; $display("FAIL t3_no_result res_valid=%b results=%0d exp 0", res_valid, got_q.size());
      end
      checks++;
      if (buf_sel !== b0 || frame_cnt !== c0) begin
         errors++; $display("FAIL t3_unchanged buf_sel=%b cnt=%0d exp %b %0d", buf_sel, frame_cnt, b0, c0);
      end
      // done on the very last allowed cycle must still win over the timeout
      start_frame(lat);
      finish_bb(64, 100, 300, 5, 6);
      wait_ack(10, seen, gs);
      note_frame(100, 300, 5, 6);
      tick();
      checks++;
      if (got_q.size() != 1) begin
         errors++; $display("FAIL t3_last_cycle_done got=%0d results exp=1", got_q.size());
      end else if (got_q[0] !== exp_q[0]) begin
         errors++; $display("FAIL t3_last_cycle_result got=%h exp=%h", got_q[0], exp_q[0]);
      end
      checks++;
      if (err_timeout !== 1'b1) begin errors++; $display("FAIL t3_err_sticky got=%b exp=1", err_timeout); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int lat, gs, a0;
      bit seen;
      res_ready = 1'b0;
      start_frame(lat);
      finish_bb(3, 1, 2, 3, 4);
      wait_ack(10, seen, gs);
      note_frame(1, 2, 3, 4);
      start_frame(lat);
      finish_bb(4, 500, 600, 700, 2000);
      a0 = ack_cnt;
      repeat (10) tick();
      checks++;
      if (ack_cnt != a0) begin errors++; $display("FAIL t4_ack_held got=%0d pulses exp=0", ack_cnt - a0); end
      checks++;
      if (res_valid !== 1'b1 || res_xmin !== 11'd1 || res_ymax !== 11'd4) begin
         errors++; $display("FAIL t4_slot_held valid=%b xmin=%0d ymax=%0d exp 1 1 4", res_valid, res_xmin, res_ymax);
      end
      res_ready = 1'b1;
      wait_ack(10, seen, gs);
      note_frame(500, 600, 700, 2000);
      checks++;
      if (!seen || gs != 1) begin
         errors++; $display("FAIL t4_ack_after_handshake seen=%b results_at_ack=%0d exp 1 1", seen, gs);
      end
      repeat (2) tick();
      checks++;
      if (got_q.size() != 2) begin
         errors++; $display("FAIL t4_result_count got=%0d exp=2", got_q.size());
      end else if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
         errors++; $display("FAIL t4_order got=%h,%h exp=%h,%h", got_q[0], got_q[1], exp_q[0], exp_q[1]);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_enable();
      int lat, hi, gs;
      bit seen;
      enable = 1'b0; frame_rdy = 1'b1; hi = 0;
      repeat (30) begin
         tick();
         if (bb_start === 1'b1) hi++;
      end
      checks++;
      if (hi != 0) begin errors++; $display("FAIL t5_disabled_start got=%0d cycles exp=0", hi); end
      enable = 1'b1;
      start_frame(lat);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL t5_enable_latency got=%0d exp=1", lat); end
      enable = 1'b0;
      finish_bb(6, 40, 41, 900, 1000);
      wait_ack(10, seen, gs);
      note_frame(40, 41, 900, 1000);
      tick();
      checks++;
      if (!seen || got_q.size() != 1) begin
         errors++; $display("FAIL t5_inflight_completes seen=%b results=%0d exp 1 1", seen, got_q.size());
      end else if (got_q[0] !== exp_q[0]) begin
         errors++; $display("FAIL t5_result got=%h exp=%h", got_q[0], exp_q[0]);
      end
      enable = 1'b1;
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_done_held();
      int lat, hi, gs;
      bit seen;
      start_frame(lat);
      repeat (2) tick();
      bb_xmin = 11'd3; bb_xmax = 11'd8; bb_ymin = 11'd0; bb_ymax = 11'd2047;
      bb_done = 1'b1;
      tick();
      wait_ack(10, seen, gs);
      note_frame(3, 8, 0, 2047);
      frame_rdy = 1'b1; hi = 0;
      repeat (10) begin
         tick();
         if (bb_start === 1'b1) hi++;
      end
      checks++;
      if (hi != 0) begin errors++; $display("FAIL done_held_no_restart got=%0d cycles exp=0", hi); end
      bb_done = 1'b0;
      start_frame(lat);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL done_held_restart_latency got=%0d exp=1", lat); end
      finish_bb(2, 0, 2047, 1, 1);
      wait_ack(10, seen, gs);
      note_frame(0, 2047, 1, 1);
      tick();
      checks++;
      if (got_q.size() != 2) begin
         errors++; $display("FAIL done_held_count got=%0d exp=2", got_q.size());
      end else if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
         errors++; $display("FAIL done_held_results got=%h,%h exp=%h,%h", got_q[0], got_q[1], exp_q[0], exp_q[1]);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      int lat, gs, mode, run, x0, x1, y0, y1, a, b, a0, frames;
      bit seen, abort;
      a0 = ack_cnt; frames = 24;
      rand_ready = 1'b1;
      for (int f = 0; f < frames; f++) begin
         mode = $urandom_range(0, 3);
         case (mode)
            0: begin
               x0 = $urandom_range(0, 2047); x1 = $urandom_range(0, 2047);
               y0 = $urandom_range(0, 2047); y1 = $urandom_range(0, 2047);
            end
            1: begin
               a = $urandom_range(0, 2047); b = $urandom_range(0, 2047);
               x0 = (a < b) ? a : b; x1 = (a < b) ? b : a;
               a = $urandom_range(0, 2047); b = $urandom_range(0, 2047);
               y0 = (a < b) ? a : b; y1 = (a < b) ? b : a;
            end
            2: begin
               x0 = 0; x1 = 2047; y0 = $urandom_range(0, 2047); y1 = 2047;
            end
            default: begin
               x0 = $urandom_range(0, 2047); x1 = x0;
               y0 = $urandom_range(0, 2047); y1 = y0;
            end
         endcase
         abort = ($urandom_range(0, 7) == 0);
         run = $urandom_range(1, 64);
         start_frame(lat);
         if (abort) begin
            wait_ack(200, seen, gs);
            exp_err = 1'b1;
         end else begin
            finish_bb(run, x0, x1, y0, y1);
            wait_ack(300, seen, gs);
            note_frame(x0, x1, y0, y1);
         end
         checks++;
         if (!seen) begin errors++; $display("FAIL rand_ack[%0d] got=0 exp=1", f); end
      end
      rand_ready = 1'b0; res_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_result_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL rand_result[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (frame_cnt !== 4'(exp_cnt)) begin
         errors++; $display("FAIL rand_frame_cnt got=%0d exp=%0d", frame_cnt, exp_cnt % 16);
      end
      checks++;
      if (buf_sel !== exp_buf) begin errors++; $display("FAIL rand_buf_sel got=%b exp=%b", buf_sel, exp_buf); end
      checks++;
      if (err_timeout !== exp_err) begin errors++; $display("FAIL rand_err got=%b exp=%b", err_timeout, exp_err); end
      checks++;
      if (ack_cnt - a0 != frames || ack_long != 0) begin
         errors++; $display("FAIL rand_ack_pulses got=%0d long=%0d exp=%0d long=0", ack_cnt - a0, ack_long, frames);
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_midframe();
      int lat, gs;
      bit seen;
      res_ready = 1'b0;
      start_frame(lat);
      finish_bb(2, 9, 19, 29, 39);
      wait_ack(10, seen, gs);
      start_frame(lat);
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bb_start !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL t6_async_drop bb_start=%b res_valid=%b exp 0 0", bb_start, res_valid);
      end
      checks++;
      if (frame_cnt !== 4'd0 || err_timeout !== 1'b0 || buf_sel !== 1'b0) begin
         errors++; $display("FAIL t6_counters cnt=%0d err=%b buf=%b exp 0 0 0", frame_cnt, err_timeout, buf_sel);
      end
      frame_rdy = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      got_q.delete(); exp_q.delete();
      exp_cnt = 0; exp_buf = 1'b0; exp_err = 1'b0;
      res_ready = 1'b1;
      tick();
      start_frame(lat);
      finish_bb(3, 12, 34, 56, 78);
      wait_ack(10, seen, gs);
      note_frame(12, 34, 56, 78);
      tick();
      checks++;
      if (frame_cnt !== 4'd1 || buf_sel !== 1'b1 || got_q.size() != 1) begin
         errors++; $display("FAIL t6_recover cnt=%0d buf=%b results=%0d exp 1 1 1", frame_cnt, buf_sel, got_q.size());
      end else if (got_q[0] !== exp_q[0]) begin
         errors++; $display("FAIL t6_recover_result got=%h exp=%h", got_q[0], exp_q[0]);
      end
   endtask

   initial begin
      checks = 0; errors = 0; ack_cnt = 0; ack_long = 0; ack_prev = 1'b0; rand_ready = 1'b0;
      exp_cnt = 0; exp_buf = 1'b0; exp_err = 1'b0;
      test_reset();
      test_basic();
      test_empty();
      test_timeout();
      test_back_to_back();
      test_enable();
      test_done_held();
      test_random();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
